pipelined_add: RTL

Parametrised, pipelined add/subtract unit for the datapath. It replaces the single-cycle 32-bit adder wherever wide operands or higher clock rates demand it. It splits a WIDTH-bit operation into STAGES carry-chained slices, one slice per pipeline stage. A valid/ready handshake on both sides lets it stall under back-pressure without losing or duplicating results.

---
 rtl/pipelined_add_if.sv | 32 +++
 rtl/pipelined_add.sv | 105 ++++++++++
 2 files changed

// File: rtl/pipelined_add_if.sv
// pipelined_add_if
//   Handshake/data bundle for the pipelined add/subtract unit.
//   Request side : in_valid, in_ready, in1, in2, sub
//   Response side: out_valid, out_ready, out, carry, overflow, zero
//   Modports:
//     master - the producer/consumer around the unit (drives operands and out_ready)
//     slave  - the unit itself (drives in_ready and the result)
interface pipelined_add_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, in1, in2, sub, out_ready,
        input  in_ready, out_valid, out, carry, overflow, zero
    );

    modport slave (
        input  in_valid, in1, in2, sub, out_ready,
        output in_ready, out_valid, out, carry, overflow, zero
    );
endinterface

// File: rtl/pipelined_add.sv
// pipelined_add
//   WIDTH-bit add/subtract split into STAGES carry-chained slices of
//   SW = WIDTH/STAGES bits, one slice resolved per pipeline stage, with an
//   elastic valid/ready pipeline (bubbles collapse, stalls hold outputs).
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset, clears every stage valid bit
//     bus    - pipelined_add_if.slave: operands/mode in, result/flags out
//   Constraints: WIDTH >= 2, 1 <= STAGES <= WIDTH, WIDTH % STAGES == 0,
//   and bus WIDTH must equal WIDTH.
module pipelined_add #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pipelined_add_if.slave bus
);
    localparam int SW = WIDTH / STAGES;

    // One word holds both the finished result slices (0..k) and the still
    // pending A slices (k+1..), so each stage just overwrites its own slice.
    typedef struct packed {
        logic [WIDTH-1:0] w;   // result slices 0..k / operand A slices k+1..
        logic [WIDTH-1:0] b;   // operand B' (already inverted for sub)
        logic             c;   // carry into the next slice
        logic             sa;  // sign of A
        logic             sb;  // sign of B'
    } stage_t;

    logic   [STAGES-1:0] valid_q;
    logic   [STAGES-1:0] valid_d;
    logic   [STAGES-1:0] load;
    logic   [STAGES-1:0] src_v;
    stage_t              src     [STAGES];
    stage_t              stage_d [STAGES];
    stage_t              stage_q [STAGES];
    logic   [WIDTH-1:0]  b_eff;
    logic   [SW:0]       slice_sum;

    // A stage may load when it is empty or its content moves on this cycle;
    // evaluated from the output backwards so bubbles anywhere open the path.
    always_comb begin
        load = '0;
        load[STAGES-1] = !valid_q[STAGES-1] || bus.out_ready;
        for (int unsigned i = 1; i < STAGES; i++) begin
            load[STAGES-1-i] = load[STAGES-i] || !valid_q[STAGES-1-i];
        end
    end

    // Source of each stage: the operand port for stage 0, the previous
    // stage register otherwise. Subtraction feeds ~B with a carry-in of 1.
    always_comb begin
        b_eff    = bus.sub ? ~bus.in2 : bus.in2;
        src_v    = '0;
        src[0]   = '{w: bus.in1, b: b_eff, c: bus.sub,
                     sa: bus.in1[WIDTH-1], sb: b_eff[WIDTH-1]};
        src_v[0] = bus.in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src[k]   = stage_q[k-1];
            src_v[k] = valid_q[k-1];
        end
    end

    always_comb begin
        slice_sum = '0;
        valid_d   = valid_q;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (load[k]) begin
                valid_d[k] = src_v[k];
            end
            stage_d[k] = src[k];
            slice_sum  = {1'b0, src[k].w[k*SW +: SW]}
                       + {1'b0, src[k].b[k*SW +: SW]}
                       + {{SW{1'b0}}, src[k].c};
            stage_d[k].w[k*SW +: SW] = slice_sum[SW-1:0];
            stage_d[k].c             = slice_sum[SW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data registers carry no reset; a bubble moving in leaves them as-is.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (load[k] && src_v[k]) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.out       = stage_q[STAGES-1].w;
    assign bus.carry     = stage_q[STAGES-1].c;
    assign bus.zero      = (stage_q[STAGES-1].w == '0);
    assign bus.overflow  = (stage_q[STAGES-1].sa == stage_q[STAGES-1].sb)
                        && (stage_q[STAGES-1].w[WIDTH-1] != stage_q[STAGES-1].sa);
endmodule
